writeback_unit: RTL
===================

# writeback_unit

Write-side driver for the 8 x 16-bit register file write port (flag / register index / data). Accepts writeback requests from the ALU and memory paths with valid/ready handshakes and buffers them in a small in-order FIFO. Drains one write per cycle into the register file through registered outputs. Provides forwarding lookups so that reads of not-yet-committed registers return the pending value.

## Interface
- DATA_W, 16, data width
- ADDR_W, 3, register index width
- DEPTH, 4, FIFO entries; power of two, at least 2
- inp_clk  in  1  clock; all state updates on rising edge
- inp_rst  in  1  reset; one clock, synchronous, active-high
- inp_memValid / inp_memReg / inp_memData  in  1 / ADDR_W / DATA_W  memory-path request
- out_memReady  out  1  memory request accepted this cycle when valid && ready
- inp_aluValid / inp_aluReg / inp_aluData  in  1 / ADDR_W / DATA_W  ALU-path request
- out_aluReady  out  1  ALU request accepted this cycle when valid && ready
- inp_wbHold  in  1  suppresses the drain pop this cycle
- out_flagWrite / out_regWrite / out_dataWrite  out  1 / ADDR_W / DATA_W  register file write port, registered
- inp_rs, inp_rd  in  ADDR_W  forwarding lookup indices
- out_fwd1Hit / out_fwd1Data, out_fwd2Hit / out_fwd2Data  out  1 / DATA_W  forwarding results for inp_rs / inp_rd
- out_count  out  clog2(DEPTH+1)  FIFO occupancy
- out_full, out_empty  out  1  count==DEPTH, count==0

## Operation
- Reset: count=0, FIFO pointers=0, out_flagWrite=0, out_regWrite=0, out_dataWrite=0. Pending entries are discarded and no write is issued.
- Pop condition: pop = (count>0) && !inp_wbHold.
- Free-slot calculation: free = DEPTH - count + pop.
- out_memReady = (free >= 1).
- out_aluReady = (free >= 1 + inp_memValid).
- Ordering: the memory request is the older instruction and takes priority.
- Enqueue order when both requests are accepted in the same cycle: mem entry first, then alu entry.
- Register 0:
  - A request targeting register 0 is accepted (handshake completes) but not stored.
  - It does not consume a slot and does not reduce free for the ALU path.
  - It never produces a write.
- Drain on pop: the head entry loads into out_regWrite/out_dataWrite, out_flagWrite=1 next cycle, and the head pointer advances.
- No pop: out_flagWrite=0 next cycle; out_regWrite/out_dataWrite hold their values.
- Pointers wrap modulo DEPTH.
- out_count is updated by pushes (0, 1 or 2) minus pop, in the same edge.
- Forwarding candidates:
  - All valid FIFO entries.
  - The output register while out_flagWrite=1; this write commits at the next edge.
- Forwarding selection:
  - Youngest matching candidate wins.
  - The output register is the oldest candidate.
  - Hit=0 and data=0 when there is no match or the index is 0.
- Requests arriving in the current cycle are not forwarded.
- Forwarding outputs are combinational from state and the lookup indices.

## Timing
- Request accepted at edge N: entry is visible to forwarding and out_count after N.
- If popped at edge N+1 (earliest): out_flagWrite=1 after N+1, and the register file commits at edge N+2.
- Drain throughput: 1 write/cycle.
- Enqueue throughput: up to 2 entries/cycle.
- Full FIFO with pop: one slot is free, so mem is accepted and alu is not (when both are valid).
- Full FIFO with inp_wbHold=1: both readys are 0.
- Empty FIFO: no pop and no flagWrite. An entry accepted this cycle is not popped until the next cycle (no fall-through).
- inp_rst dominates a simultaneous push/pop: state is cleared and the handshake is ignored. Readys may be high during reset, but the accepted data is discarded.

## Test plan
- Reset, then alu r3=0x1234 accepted at edge N -> out_flagWrite=1, out_regWrite=3, out_dataWrite=0x1234 during cycle after N+1 only. inp_rs=3 gives out_fwd1Hit=1 and data 0x1234 for the two cycles after N.
- Empty FIFO, mem r1=0xAAAA and alu r1=0x5555 in the same cycle -> both readys=1, count=2, and inp_rs=1 forwards 0x5555. Writes appear on consecutive cycles, 0xAAAA then 0x5555.
- inp_wbHold=1 and 4 single alu writes r2..r5 -> count=4, out_full=1, out_aluReady=0. Release hold with a 5th request pending -> it is accepted on the first pop cycle, then 5 consecutive in-order writes.
- Full FIFO, hold=0, both valid -> out_memReady=1, out_aluReady=0, count stays 4.
- alu write to r0 with value 0xFFFF -> out_aluReady=1, count unchanged, no out_flagWrite. Lookup of index 0 gives hit=0.
- 3 entries pending, assert inp_rst for one cycle -> after the edge, count=0, out_empty=1, out_flagWrite=0, all forwarding hits 0, and no writes afterward.

Source files
------------

// File: rtl/writeback_unit.sv
// Register-file write-side driver: buffers ALU/memory writebacks in an in-order FIFO,
// drains one write per cycle through a registered port, and forwards pending values.
module writeback_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              inp_clk,
    input  logic              inp_rst,
    input  logic              inp_memValid,
    input  logic [ADDR_W-1:0] inp_memReg,
    input  logic [DATA_W-1:0] inp_memData,
    output logic              out_memReady,
    input  logic              inp_aluValid,
    input  logic [ADDR_W-1:0] inp_aluReg,
    input  logic [DATA_W-1:0] inp_aluData,
    output logic              out_aluReady,
    input  logic              inp_wbHold,
    output logic              out_flagWrite,
    output logic [ADDR_W-1:0] out_regWrite,
    output logic [DATA_W-1:0] out_dataWrite,
    input  logic [ADDR_W-1:0] inp_rs,
    input  logic [ADDR_W-1:0] inp_rd,
    output logic              out_fwd1Hit,
    output logic [DATA_W-1:0] out_fwd1Data,
    output logic              out_fwd2Hit,
    output logic [DATA_W-1:0] out_fwd2Data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_full,
    output logic              out_empty
);

    logic [ADDR_W-1:0] entry_reg  [DEPTH];
    logic [DATA_W-1:0] entry_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  alu_slot;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    free;
    logic [CNT_W:0]    alu_need;
    logic [1:0]        push_n;
    logic              pop;
    logic              mem_takes_slot;
    logic              mem_push;
    logic              alu_push;

    // Handshake: register-0 requests complete the handshake but never occupy a slot.
    always_comb begin
        pop            = (count != '0) && !inp_wbHold;
        free           = (CNT_W + 1)'(DEPTH) - {1'b0, count} + {{CNT_W{1'b0}}, pop};
        mem_takes_slot = inp_memValid && (inp_memReg != '0);
        alu_need       = (CNT_W + 1)'(1) + {{CNT_W{1'b0}}, mem_takes_slot};
        out_memReady   = free >= (CNT_W + 1)'(1);
        out_aluReady   = free >= alu_need;
        mem_push       = mem_takes_slot && out_memReady;
        alu_push       = inp_aluValid && out_aluReady && (inp_aluReg != '0);
        push_n         = {1'b0, mem_push} + {1'b0, alu_push};
        alu_slot       = mem_push ? tail + PTR_W'(1) : tail;
    end

    // Entry storage: no reset needed, occupancy alone decides which slots are live.
    always_ff @(posedge inp_clk) begin
        if (mem_push) begin
            entry_reg[tail]  <= inp_memReg;
            entry_data[tail] <= inp_memData;
        end
        if (alu_push) begin
            entry_reg[alu_slot]  <= inp_aluReg;
            entry_data[alu_slot] <= inp_aluData;
        end
    end

    // Drain stage: head entry moves into the registered write port.
    always_ff @(posedge inp_clk) begin
        if (inp_rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            out_flagWrite <= 1'b0;
            out_regWrite  <= '0;
            out_dataWrite <= '0;
        end else begin
            tail  <= tail + PTR_W'(push_n);
            count <= count + CNT_W'(push_n) - CNT_W'(pop);
            if (pop) begin
                head          <= head + PTR_W'(1);
                out_flagWrite <= 1'b1;
                out_regWrite  <= entry_reg[head];
                out_dataWrite <= entry_data[head];
            end else begin
                out_flagWrite <= 1'b0;
            end
        end
    end

    // Scan oldest to youngest so the youngest match overwrites earlier hits.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] idx);
        logic              hit;
        logic [DATA_W-1:0] data;
        logic [PTR_W-1:0]  slot;
        hit  = 1'b0;
        data = '0;
        if (idx != '0) begin
            if (out_flagWrite && (out_regWrite == idx)) begin
                hit  = 1'b1;
                data = out_dataWrite;
            end
            for (int i = 0; i < DEPTH; i++) begin
                slot = head + PTR_W'(i);
                if ((CNT_W'(i) < count) && (entry_reg[slot] == idx)) begin
                    hit  = 1'b1;
                    data = entry_data[slot];
                end
            end
        end
        return {hit, data};
    endfunction

    always_comb begin
        {out_fwd1Hit, out_fwd1Data} = lookup(inp_rs);
        {out_fwd2Hit, out_fwd2Data} = lookup(inp_rd);
    end

    assign out_count = count;
    assign out_full  = (count == CNT_W'(DEPTH));
    assign out_empty = (count == '0);

endmodule
